// File: rtl/dm_access_ctrl.sv
// MEM-stage load/store sequencer: byte lanes, store replication, load extension, watchdog abort (ALIGN_EXC_EN: trap misaligned).
// Latency: done one cycle after mem_ready (min 2 cycles); misaligned trap in 1; watchdog abort after MAX_WAIT.
// Backpressure: busy stalls the pipeline combinationally from the request cycle until the done cycle.
module dm_access_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_uns,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        lat_we;
    logic        lat_uns;
    logic [1:0]  lat_size;
    logic [1:0]  lat_lo;
    logic        misalign;

    function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   be_of = 4'b0001 << lo;
            2'b01:   be_of = lo[1] ? 4'b1100 : 4'b0011;
            default: be_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   wdata_of = {4{d[7:0]}};
            2'b01:   wdata_of = {2{d[15:0]}};
            default: wdata_of = d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] size, input logic uns,
                                            input logic [1:0] lo, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   extract = {{24{~uns & b[7]}}, b};
            2'b01:   extract = {{16{~uns & h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

`ifdef ALIGN_EXC_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign busy = req_valid && (state != RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= '0;
            lat_lo    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    rdata <= '0;
                    if (req_valid) begin
                        lat_we   <= req_we;
                        lat_uns  <= req_uns;
                        lat_size <= req_size;
                        lat_lo   <= req_addr[1:0];
                        wait_cnt <= '0;
                        if (misalign) begin
                            state <= RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            mem_en    <= 1'b1;
                            mem_we    <= req_we;
                            mem_be    <= be_of(req_size, req_addr[1:0]);
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= wdata_of(req_size, req_wdata);
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready || (wait_cnt == 8'(MAX_WAIT - 1))) begin
                        state     <= RESP;
                        done      <= 1'b1;
                        err       <= ~mem_ready;
                        rdata     <= (mem_ready && !lat_we) ?
                                     extract(lat_size, lat_uns, lat_lo, mem_rdata) : 32'h0;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: hand-computed lane, extension, latency, watchdog and reset cases.
module tb_dm_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_uns;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;

    int n_chk  = 0;
    int n_fail = 0;

    dm_access_ctrl #(.MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size), .req_uns(req_uns),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    // Request in cycle 0, `waits` idle ACCESS cycles, mem_ready in the next, done one after that.
    task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input int waits, input logic [31:0] mword, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        int busy_cnt;
        tick();
        drive_req(we, size, uns, addr, wdata);
        mem_ready = 1'b0;
        #1;
        chk({tag, "_busy_req"}, 32'(busy), 32'd1);
        chk({tag, "_en_req"}, 32'(mem_en), 32'd0);
        busy_cnt = int'(busy);
        for (int i = 0; i < waits; i++) begin
            tick();
            busy_cnt += int'(busy);
        end
        tick();
        mem_ready = 1'b1;
        mem_rdata = mword;
        #1;
        busy_cnt += int'(busy);
        chk({tag, "_en"}, 32'(mem_en), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'(we));
        chk({tag, "_be"}, 32'(mem_be), 32'(exp_be));
        chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        if (we) chk({tag, "_wdata"}, mem_wdata, exp_wd);
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        req_valid = 1'b0;
        #1;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_rdata"}, rdata, exp_rd);
        chk({tag, "_en_off"}, 32'(mem_en), 32'd0);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(waits + 2));
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int en_cnt;
        int done_cyc;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_uns = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
        tick();
        tick();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_en", 32'(mem_en), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;

        // mem_ready outside ACCESS must not produce a done
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("idle_ready_done", 32'(done), 32'd0);

        do_access("lb",   1'b0, 2'b00, 1'b0, 32'h1000_0003, 32'h0, 0, 32'h80FF_1234,
                  4'b1000, 32'h0, 32'hFFFF_FF80);
        do_access("lhu",  1'b0, 2'b01, 1'b1, 32'h1000_0002, 32'h0, 3, 32'h9ABC_5678,
                  4'b1100, 32'h0, 32'h0000_9ABC);
        do_access("sb",   1'b1, 2'b00, 1'b0, 32'h1000_0001, 32'h1234_56A5, 1, 32'hFFFF_FFFF,
                  4'b0010, 32'hA5A5_A5A5, 32'h0);
        do_access("lbu",  1'b0, 2'b00, 1'b1, 32'h2000_0001, 32'h0, 0, 32'h1234_8056,
                  4'b0010, 32'h0, 32'h0000_0080);
        do_access("sh",   1'b1, 2'b01, 1'b0, 32'h2000_0006, 32'hDEAD_BEEF, 2, 32'h0,
                  4'b1100, 32'hBEEF_BEEF, 32'h0);
        do_access("lh0",  1'b0, 2'b01, 1'b0, 32'h2000_0000, 32'h0, 0, 32'h1234_F00D,
                  4'b0011, 32'h0, 32'hFFFF_F00D);
        do_access("swr",  1'b1, 2'b11, 1'b0, 32'h3000_0008, 32'hCAFE_0123, 0, 32'h0,
                  4'b1111, 32'hCAFE_0123, 32'h0);

`ifdef ALIGN_EXC_EN
        tick();
        drive_req(1'b0, 2'b10, 1'b0, 32'h4000_0002, 32'h0);
        #1;
        chk("mis_busy", 32'(busy), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("mis_en", 32'(mem_en), 32'd0);
        chk("mis_done", 32'(done), 32'd1);
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_rdata", rdata, 32'd0);
`else
        do_access("lw_mis", 1'b0, 2'b10, 1'b0, 32'h4000_0002, 32'h0, 0, 32'h8765_4321,
                  4'b1111, 32'h0, 32'h8765_4321);
        do_access("lh_mis", 1'b0, 2'b01, 1'b1, 32'h4000_0003, 32'h0, 0, 32'h8765_4321,
                  4'b1100, 32'h0, 32'h0000_8765);
`endif

        // watchdog: no mem_ready ever
        tick();
        drive_req(1'b1, 2'b10, 1'b0, 32'h5000_0010, 32'h1111_2222);
        en_cnt = 0;
        done_cyc = -1;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            tick();
            if (done) begin
                done_cyc = c;
                chk("wd_err", 32'(err), 32'd1);
                chk("wd_en_off", 32'(mem_en), 32'd0);
                chk("wd_rdata", rdata, 32'd0);
                req_valid = 1'b0;
            end else begin
                en_cnt += int'(mem_en);
            end
        end
        chk("wd_en_cycles", 32'(en_cnt), 32'd15);
        chk("wd_done_cycle", 32'(done_cyc), 32'd16);
        tick();

        // reset in the second ACCESS cycle
        tick();
        drive_req(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        tick();
        chk("rmid_en1", 32'(mem_en), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("rmid_en", 32'(mem_en), 32'd0);
        chk("rmid_done", 32'(done), 32'd0);
        chk("rmid_err", 32'(err), 32'd0);
        chk("rmid_be", 32'(mem_be), 32'd0);
        tick();
        reset = 1'b0;
        req_valid = 1'b0;
        tick();
        chk("rmid_idle_done", 32'(done), 32'd0);
        do_access("lh_post", 1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 0, 32'h0000_8001,
                  4'b0011, 32'h0, 32'hFFFF_8001);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
